sram_arbiter: RTL

- Shares the single external 512Kx8 SRAM between two requesters: the video fetcher (read-only, high priority) and the CPU bus (read/write).
- Sits between the core's memory-decode logic and the SRAM pins, clocked from the 28 MHz system clock.
- Sequences every access as SETUP/STROBE/DONE, so sram_we_n is never low while the address changes.
- Bounds CPU starvation with a loss counter.

---
 rtl/zxuno_mem_pkg.sv | 19 +
 rtl/sram_arbiter_if.sv | 39 +++
 rtl/sram_arb_select.sv | 50 +++++
 rtl/sram_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/zxuno_mem_pkg.sv
// Shared definitions for the SRAM arbiter: FSM states, SRAM geometry and
// the encoding that names which requester owns the current access.
package zxuno_mem_pkg;

   localparam int SRAM_AW = 19;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic {
      PORT_VID = 1'b0,
      PORT_CPU = 1'b1
   } port_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pad signals of the arbiter. The slave modport is the
// arbiter itself; the master modport is everything around it.
interface sram_arbiter_if
   import zxuno_mem_pkg::*;
#(
   parameter int AW = SRAM_AW
);

   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_ack;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic          cpu_ack;
   logic [7:0]    rdata;
   logic          busy;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_data_in;
   logic [7:0]    sram_data_out;
   logic          sram_data_oe;
   logic          sram_we_n;

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
             sram_data_in,
      input  vid_ack, cpu_ack, rdata, busy, sram_addr, sram_data_out,
             sram_data_oe, sram_we_n
   );

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
             sram_data_in,
      output vid_ack, cpu_ack, rdata, busy, sram_addr, sram_data_out,
             sram_data_oe, sram_we_n
   );

endinterface

// File: rtl/sram_arb_select.sv
// Winner selection between video and CPU, with a loss counter that forces a
// CPU grant after CPU_STARVE_MAX consecutive losses.
module sram_arb_select
   import zxuno_mem_pkg::*;
#(
   parameter int CPU_STARVE_MAX = 2
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  vid_req,
   input  logic  cpu_req,
   input  logic  arbitrate,
   output logic  grant_valid,
   output port_t grant
);

   localparam logic [2:0] STARVE_LIMIT = 3'(CPU_STARVE_MAX);

   logic [2:0] loss_reg;
   logic [2:0] loss_next;

   always_comb begin
      grant_valid = vid_req | cpu_req;
      grant       = PORT_VID;
      if (cpu_req && (!vid_req || loss_reg == STARVE_LIMIT)) begin
         grant = PORT_CPU;
      end
   end

   // The count never passes the limit because reaching it hands the CPU the next grant.
   always_comb begin
      loss_next = loss_reg;
      if (arbitrate) begin
         if (!cpu_req || grant == PORT_CPU) begin
            loss_next = '0;
         end else if (loss_reg != STARVE_LIMIT) begin
            loss_next = loss_reg + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_reg <= '0;
      end else begin
         loss_reg <= loss_next;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the external SRAM. Every access runs SETUP, STROBE,
// DONE so the write strobe is never low while the address moves.
module sram_arbiter
   import zxuno_mem_pkg::*;
#(
   parameter int AW             = SRAM_AW,
   parameter int WAIT_STATES    = 0,
   parameter int CPU_STARVE_MAX = 2
) (
   input  logic           clk,
   input  logic           power_on_reset_n,
   sram_arbiter_if.slave  bus
);

   localparam logic [1:0] WS_LAST = 2'(WAIT_STATES);

   state_t        state_reg;
   state_t        state_next;
   logic [1:0]    wait_reg;
   port_t         port_reg;
   logic          we_reg;
   logic [AW-1:0] addr_reg;
   logic [7:0]    data_out_reg;
   logic          oe_reg;
   logic          we_n_reg;
   logic          vid_ack_reg;
   logic          cpu_ack_reg;
   logic [7:0]    rdata_reg;

   logic          arbitrate;
   logic          strobe_last;
   logic          grant_valid;
   port_t         grant;

   sram_arb_select #(
      .CPU_STARVE_MAX (CPU_STARVE_MAX)
   ) u_select (
      .clk         (clk),
      .rst_n       (power_on_reset_n),
      .vid_req     (bus.vid_req),
      .cpu_req     (bus.cpu_req),
      .arbitrate   (arbitrate),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   always_comb begin
      state_next  = state_reg;
      arbitrate   = 1'b0;
      strobe_last = 1'b0;
      case (state_reg)
         IDLE: begin
            arbitrate = 1'b1;
            if (grant_valid) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            state_next = STROBE;
         end
         STROBE: begin
            strobe_last = (wait_reg == WS_LAST);
            if (wait_reg == WS_LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         state_reg    <= IDLE;
         wait_reg     <= '0;
         port_reg     <= PORT_VID;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         data_out_reg <= '0;
         oe_reg       <= 1'b0;
         we_n_reg     <= 1'b1;
         vid_ack_reg  <= 1'b0;
         cpu_ack_reg  <= 1'b0;
         rdata_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         vid_ack_reg <= 1'b0;
         cpu_ack_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_valid) begin
                  port_reg <= grant;
                  if (grant == PORT_CPU) begin
                     addr_reg     <= bus.cpu_addr;
                     we_reg       <= bus.cpu_we;
                     data_out_reg <= bus.cpu_wdata;
                     oe_reg       <= bus.cpu_we;
                  end else begin
                     // Video is read-only; its write operands do not exist.
                     addr_reg <= bus.vid_addr;
                     we_reg   <= 1'b0;
                     oe_reg   <= 1'b0;
                  end
               end
            end
            SETUP: begin
               wait_reg <= '0;
               we_n_reg <= ~we_reg;
            end
            STROBE: begin
               wait_reg <= wait_reg + 2'd1;
               if (strobe_last) begin
                  we_n_reg    <= 1'b1;
                  vid_ack_reg <= (port_reg == PORT_VID);
                  cpu_ack_reg <= (port_reg == PORT_CPU);
                  if (!we_reg) begin
                     rdata_reg <= bus.sram_data_in;
                  end
               end
            end
            DONE: begin
               // Data stays driven through DONE to give the SRAM write hold time.
               oe_reg <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.vid_ack       = vid_ack_reg;
   assign bus.cpu_ack       = cpu_ack_reg;
   assign bus.rdata         = rdata_reg;
   assign bus.busy          = (state_reg != IDLE);
   assign bus.sram_addr     = addr_reg;
   assign bus.sram_data_out = data_out_reg;
   assign bus.sram_data_oe  = oe_reg;
   assign bus.sram_we_n     = we_n_reg;

endmodule
